// File: rtl/relu_pkg.sv
// Shared definitions for the ReLU forward/backward paths: state encoding,
// default geometry and the sign-extract helper used for mask generation.
package relu_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    LOADED = 1'b1
  } state_t;

  localparam int DEF_W          = 5;
  localparam int DEF_H          = 5;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LEAK_SHIFT = 3;
  localparam int N              = DEF_W * DEF_H;

  // Two's-complement sign bit; zero counts as non-negative.
  function automatic logic is_negative(input logic [DEF_DATA_WIDTH-1:0] v);
    return v[DEF_DATA_WIDTH-1];
  endfunction

endpackage

// File: rtl/relu_backprop_stream_if.sv
// Stream bundle for relu_backprop_stream: forward-map capture, upstream
// gradient input, gated gradient output and status.
interface relu_backprop_stream_if
  import relu_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int H          = DEF_H,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int NUM = W * H;

  // Handshake rule for fwd, g and o channels: a beat transfers on a rising
  // edge where valid && ready; the source holds valid and data stable until
  // that edge, and ready may depend combinationally on valid.
  logic                      clear;
  logic [NUM*DATA_WIDTH-1:0] fwd_in;
  logic                      fwd_valid;
  logic                      fwd_ready;
  logic [DATA_WIDTH-1:0]     g_data;
  logic                      g_valid;
  logic                      g_ready;
  logic [DATA_WIDTH-1:0]     o_data;
  logic                      o_valid;
  logic                      o_ready;
  logic                      o_last;
  logic                      mask_loaded;

  modport master (
    output clear, fwd_in, fwd_valid, g_data, g_valid, o_ready,
    input  fwd_ready, g_ready, o_data, o_valid, o_last, mask_loaded
  );

  modport slave (
    input  clear, fwd_in, fwd_valid, g_data, g_valid, o_ready,
    output fwd_ready, g_ready, o_data, o_valid, o_last, mask_loaded
  );

endinterface

// File: rtl/relu_grad_gate.sv
// Per-element gradient gate: pass the gradient where the forward value was
// non-negative. LEAKY_GRAD_EN selects a scaled (>>> LEAK_SHIFT) leak instead of zero.
module relu_grad_gate #(
  parameter int DATA_WIDTH = 16
`ifdef LEAKY_GRAD_EN
  , parameter int LEAK_SHIFT = 3
`endif
) (
  input  logic                  pass,
  input  logic [DATA_WIDTH-1:0] g,
  output logic [DATA_WIDTH-1:0] result
);

`ifdef LEAKY_GRAD_EN
  assign result = pass ? g : DATA_WIDTH'($signed(g) >>> LEAK_SHIFT);
`else
  assign result = pass ? g : '0;
`endif

endmodule

// File: rtl/relu_backprop_stream.sv
// ReLU backward path: captures the forward map's sign mask, then gates one
// gradient element per beat. Optional leak variant under LEAKY_GRAD_EN.
module relu_backprop_stream
  import relu_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int H          = DEF_H,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef LEAKY_GRAD_EN
  , parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  relu_backprop_stream_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int NUM   = W * H;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  state_t                state;
  logic [NUM-1:0]        mask;
  logic [NUM-1:0]        fwd_mask;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] o_data_q;
  logic [DATA_WIDTH-1:0] gated;
  logic                  o_valid_q;
  logic                  o_last_q;
  logic                  fwd_ready;
  logic                  g_ready;
  logic                  fwd_fire;
  logic                  g_fire;

  for (genvar i = 0; i < NUM; i++) begin : g_mask
    assign fwd_mask[i] = ~is_negative(bus.fwd_in[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Capture only on a frame boundary with nothing pending; a capture
  // request stalls any gradient offered in the same cycle.
  assign fwd_ready = (idx == '0) && !o_valid_q;
  assign fwd_fire  = bus.fwd_valid && fwd_ready;
  assign g_ready   = (state == LOADED) && (!o_valid_q || bus.o_ready) && !fwd_fire;
  assign g_fire    = bus.g_valid && g_ready;

  relu_grad_gate #(
    .DATA_WIDTH (DATA_WIDTH)
`ifdef LEAKY_GRAD_EN
    , .LEAK_SHIFT (LEAK_SHIFT)
`endif
  ) u_gate (
    .pass   (mask[idx]),
    .g      (bus.g_data),
    .result (gated)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      mask      <= '0;
      idx       <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (bus.clear) begin
      state     <= EMPTY;
      mask      <= '0;
      idx       <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      if (fwd_fire) begin
        mask  <= fwd_mask;
        state <= LOADED;
      end
      if (g_fire) begin
        o_data_q  <= gated;
        o_valid_q <= 1'b1;
        o_last_q  <= (idx == IDX_W'(NUM-1));
        idx       <= (idx == IDX_W'(NUM-1)) ? '0 : idx + 1'b1;
      end else if (o_valid_q && bus.o_ready) begin
        o_valid_q <= 1'b0;
        o_last_q  <= 1'b0;
      end
    end
  end

  assign bus.fwd_ready   = fwd_ready;
  assign bus.g_ready     = g_ready;
  assign bus.o_data      = o_data_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_last      = o_last_q;
  assign bus.mask_loaded = (state == LOADED);
  assign dbg_state       = state;

endmodule

// File: tb/tb_relu_backprop_stream.sv
// Directed bench for relu_backprop_stream (W=H=5, DATA_WIDTH=16); leak
// expectations follow LEAKY_GRAD_EN.
module tb_relu_backprop_stream;
  import relu_pkg::*;

  localparam int DW = 16;
  localparam int NE = 25;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  relu_backprop_stream_if #(.W(5), .H(5), .DATA_WIDTH(DW)) bus ();

  relu_backprop_stream #(.W(5), .H(5), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [16:0]   exp_q[$];
  logic [DW-1:0] map_v[NE];
  logic [DW-1:0] g_vec[NE];
  logic [DW-1:0] exp_tab[NE];
  bit            mon_en = 1'b0;
  bit            held = 1'b0;
  logic [DW-1:0] held_val;
  int            cyc = 0;
  int            frame_out = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  int            stalls;

  always @(posedge clk) cyc <= cyc + 1;

  // Output scoreboard and stall-stability monitor
  always @(negedge clk) begin
    logic [16:0] e;
    if (mon_en && rst_n) begin
      if (held && bus.o_valid) check("hold_stable", bus.o_data, held_val);
      if (bus.o_valid && bus.o_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("o_data", bus.o_data, e[15:0]);
          check("o_last", bus.o_last, e[16]);
        end
        if (frame_out == 0) first_cyc = cyc;
        if (frame_out == NE-1) last_cyc = cyc;
        frame_out++;
        held = 1'b0;
      end else if (bus.o_valid) begin
        held = 1'b1;
        held_val = bus.o_data;
      end else held = 1'b0;
    end
  end

  task automatic load_map();
    for (int i = 0; i < NE; i++) bus.fwd_in[i*DW +: DW] = map_v[i];
  endtask

  task automatic capture();
    int guard = 0;
    load_map();
    bus.fwd_valid = 1'b1;
    @(negedge clk);
    while (!bus.fwd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("capture_ready", bus.fwd_ready, 1);
    @(posedge clk); #1;
    bus.fwd_valid = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input bit bp, input bit drop_last, output int n_stall);
    int sent = 0;
    int guard = 0;
    bit fire;
    n_stall = 0;
    frame_out = 0;
    bus.g_data = g_vec[0];
    bus.g_valid = 1'b1;
    while (sent < nbeats && guard < 2000) begin
      bus.o_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      fire = bus.g_valid && bus.g_ready;
      @(posedge clk); #1;
      if (fire) begin
        if (!(drop_last && sent == nbeats-1)) exp_q.push_back({sent == NE-1, exp_tab[sent]});
        sent++;
        bus.g_data = g_vec[sent % NE];
      end else n_stall++;
      guard++;
    end
    bus.g_valid = 1'b0;
    check("send_done", sent, nbeats);
  endtask

  task automatic drain();
    int guard = 0;
    bus.o_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic alt_frame();
    for (int i = 0; i < NE; i++) begin
      map_v[i] = (i % 2 == 0) ? 16'hffff : 16'h0fff;
      g_vec[i] = 16'h0010;
`ifdef LEAKY_GRAD_EN
      exp_tab[i] = (i % 2 == 1) ? 16'h0010 : 16'h0002;
`else
      exp_tab[i] = (i % 2 == 1) ? 16'h0010 : 16'h0000;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.clear = 1'b0; bus.fwd_valid = 1'b0; bus.fwd_in = '0;
    bus.g_valid = 1'b0; bus.g_data = '0; bus.o_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: asynchronous reset in the middle of a stream
    alt_frame();
    capture();
    bus.g_valid = 1'b1;
    bus.g_data = 16'h0010;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_o_data", bus.o_data, 0);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_last", bus.o_last, 0);
    check("rst_mask_loaded", bus.mask_loaded, 0);
    check("rst_fwd_ready", bus.fwd_ready, 1);
    check("rst_g_ready", bus.g_ready, 0);
    check("rst_state", dbg_state, EMPTY);
    bus.g_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    held = 1'b0;
    mon_en = 1'b1;

    // 2: alternating map, full throughput
    alt_frame();
    capture();
    check("t2_mask_loaded", bus.mask_loaded, 1);
    send_frame(NE, 1'b0, 1'b0, stalls);
    check("t2_stalls", stalls, 0);
    drain();
    check("t2_throughput", last_cyc - first_cyc, NE-1);

    // 3: same mask reused under random backpressure
    send_frame(NE, 1'b1, 1'b0, stalls);
    drain();

    // 4: capture and gradient offered together at idx 0
    for (int i = 0; i < NE; i++) begin
      map_v[i] = (i % 2 == 0) ? 16'h0000 : 16'h8000;
      g_vec[i] = 16'((i + 1) * 16);
`ifdef LEAKY_GRAD_EN
      exp_tab[i] = (i % 2 == 0) ? 16'((i + 1) * 16) : 16'((i + 1) * 2);
`else
      exp_tab[i] = (i % 2 == 0) ? 16'((i + 1) * 16) : 16'h0000;
`endif
    end
    load_map();
    bus.fwd_valid = 1'b1;
    bus.g_valid = 1'b1;
    bus.g_data = g_vec[0];
    @(negedge clk);
    check("t4_fwd_ready", bus.fwd_ready, 1);
    check("t4_g_ready", bus.g_ready, 0);
    @(posedge clk); #1;
    bus.fwd_valid = 1'b0;
    check("t4_state", dbg_state, LOADED);
    send_frame(NE, 1'b0, 1'b0, stalls);
    check("t4_stalls", stalls, 0);
    drain();

    // 5: clear after 10 beats drops the pending output and the mask
    alt_frame();
    capture();
    send_frame(10, 1'b0, 1'b1, stalls);
    bus.o_ready = 1'b0;
    bus.clear = 1'b1;
    bus.g_valid = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    @(negedge clk);
    check("t5_o_valid", bus.o_valid, 0);
    check("t5_mask_loaded", bus.mask_loaded, 0);
    check("t5_g_ready", bus.g_ready, 0);
    check("t5_fwd_ready", bus.fwd_ready, 1);
    check("t5_exp_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    check("t5_empty_no_output", bus.o_valid, 0);
    bus.g_valid = 1'b0;
    bus.o_ready = 1'b1;
    capture();
    send_frame(NE, 1'b0, 1'b0, stalls);
    drain();

    // 6: negative positions (leak or zero)
    for (int i = 0; i < NE; i++) begin
      map_v[i] = 16'hffff;
      g_vec[i] = 16'h1230;
`ifdef LEAKY_GRAD_EN
      exp_tab[i] = 16'h0246;
`else
      exp_tab[i] = 16'h0000;
`endif
    end
    g_vec[0] = 16'hff80;
    g_vec[1] = 16'h0040;
`ifdef LEAKY_GRAD_EN
    exp_tab[0] = 16'hfff0;
    exp_tab[1] = 16'h0008;
`endif
    capture();
    send_frame(NE, 1'b0, 1'b0, stalls);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
